ip_codma_crc_engine: RTL and testbench

Parametrised CRC engine for the CODMA datapath. It replaces the pass-through CRC stage with a real reflected CRC computation over a captured block of up to NUM_WORDS data words, processing one word per cycle. It exposes a start/busy/done handshake to the DMA state machine. It also supports chaining, so a CRC can span several consecutive blocks of one transfer.

---
 rtl/ip_codma_crc_pkg.sv | 14 +
 rtl/ip_codma_crc_step.sv | 26 ++
 rtl/ip_codma_crc_engine.sv | 113 +++++++++++
 tb/tb_ip_codma_crc_engine.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/ip_codma_crc_pkg.sv
// Shared types and CRC-32/ISO-HDLC defaults for the CODMA CRC engine.
package ip_codma_crc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } crc_state_t;

  localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT      = 32'hFFFFFFFF;
  localparam logic [31:0] CRC32_XOROUT    = 32'hFFFFFFFF;

endpackage

// File: rtl/ip_codma_crc_step.sv
// One-word reflected CRC update: bit 0 of the word is folded in first, so
// bytes are consumed LSB-first with each byte bit-reflected.
module ip_codma_crc_step
  import ip_codma_crc_pkg::*;
#(
  parameter int               WORD_W = 32,
  parameter int               CRC_W  = 32,
  parameter logic [CRC_W-1:0] POLY   = CRC32_POLY_REFL
) (
  input  logic [CRC_W-1:0]  state_cur,
  input  logic [WORD_W-1:0] data_word,
  output logic [CRC_W-1:0]  state_nxt
);

  always_comb begin
    state_nxt = state_cur;
    for (int i = 0; i < WORD_W; i++) begin
      if (state_nxt[0] ^ data_word[i]) begin
        state_nxt = (state_nxt >> 1) ^ POLY;
      end else begin
        state_nxt = state_nxt >> 1;
      end
    end
  end

endmodule

// File: rtl/ip_codma_crc_engine.sv
// Block CRC engine: captures up to NUM_WORDS words on start, folds one word
// per cycle, and reports the finalised CRC with a one-cycle done pulse.
module ip_codma_crc_engine
  import ip_codma_crc_pkg::*;
#(
  parameter int               WORD_W    = 32,
  parameter int               NUM_WORDS = 8,
  parameter int               CRC_W     = 32,
  parameter logic [CRC_W-1:0] POLY      = CRC32_POLY_REFL,
  parameter logic [CRC_W-1:0] INIT      = CRC32_INIT,
  parameter logic [CRC_W-1:0] XOROUT    = CRC32_XOROUT,
  localparam int              LEN_W     = $clog2(NUM_WORDS + 1)
) (
  input  logic                              clk_i,
  input  logic                              reset_i,
  input  logic                              start_i,
  input  logic                              chain_i,
  input  logic [LEN_W-1:0]                  len_i,
  input  logic [NUM_WORDS-1:0][WORD_W-1:0]  data_i,
  output logic                              busy_o,
  output logic                              done_o,
  output logic [CRC_W-1:0]                  crc_o
);

  localparam int               IDX_W   = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(NUM_WORDS);

  crc_state_t                       fsm_reg;
  logic [LEN_W-1:0]                 idx_reg;
  logic [LEN_W-1:0]                 len_reg;
  logic [CRC_W-1:0]                 state_reg;
  logic [CRC_W-1:0]                 crc_reg;
  logic                             done_reg;
  logic [NUM_WORDS-1:0][WORD_W-1:0] data_buf_reg;

  logic [LEN_W-1:0]  len_clamped;
  logic [CRC_W-1:0]  seed;
  logic [CRC_W-1:0]  step_out;
  logic [WORD_W-1:0] cur_word;
  logic              accept;

  assign len_clamped = (len_i > MAX_LEN) ? MAX_LEN : len_i;
  assign seed        = chain_i ? state_reg : INIT;
  assign accept      = (fsm_reg == IDLE) && start_i;
  assign cur_word    = data_buf_reg[idx_reg[IDX_W-1:0]];

  ip_codma_crc_step #(
    .WORD_W (WORD_W),
    .CRC_W  (CRC_W),
    .POLY   (POLY)
  ) u_step (
    .state_cur (state_reg),
    .data_word (cur_word),
    .state_nxt (step_out)
  );

  // The block buffer needs no reset: it is only read after a fresh capture.
  always_ff @(posedge clk_i) begin
    if (accept && !reset_i) begin
      data_buf_reg <= data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      fsm_reg   <= IDLE;
      state_reg <= INIT;
      idx_reg   <= '0;
      len_reg   <= '0;
      done_reg  <= 1'b0;
      crc_reg   <= '0;
    end else begin
      done_reg <= 1'b0;
      case (fsm_reg)
        IDLE: begin
          if (start_i) begin
            len_reg   <= len_clamped;
            state_reg <= seed;
            idx_reg   <= '0;
            // An empty block finalises the seed straight away.
            if (len_clamped == '0) begin
              fsm_reg  <= DONE;
              done_reg <= 1'b1;
              crc_reg  <= seed ^ XOROUT;
            end else begin
              fsm_reg <= RUN;
            end
          end
        end
        RUN: begin
          state_reg <= step_out;
          idx_reg   <= idx_reg + 1'b1;
          if (idx_reg == len_reg - 1'b1) begin
            fsm_reg  <= DONE;
            done_reg <= 1'b1;
            crc_reg  <= step_out ^ XOROUT;
          end
        end
        DONE: begin
          fsm_reg <= IDLE;
        end
        default: begin
          fsm_reg <= IDLE;
        end
      endcase
    end
  end

  assign busy_o = (fsm_reg != IDLE);
  assign done_o = done_reg;
  assign crc_o  = crc_reg;

endmodule

// File: tb/tb_ip_codma_crc_engine.sv
// Scoreboard bench for ip_codma_crc_engine: expected CRC and completion cycle
// are queued at each accepted start and checked when done_o fires.
module tb_ip_codma_crc_engine;

  logic            clk_i = 1'b0;
  logic            reset_i;
  logic            start_i;
  logic            chain_i;
  logic [3:0]      len_i;
  logic [7:0][31:0] data_i;
  logic            busy_o;
  logic            done_o;
  logic [31:0]     crc_o;

  typedef struct {
    logic [31:0] crc;
    int          due;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        exp_e;
  exp_t        got_e;
  int          checks = 0;
  int          errors = 0;
  int          cyc_cnt = 0;
  logic [31:0] model_state = 32'hFFFFFFFF;
  logic [31:0] last_crc = '0;
  logic [31:0] prev_crc;
  int          last_done_cyc = 0;
  int          prev_done_cyc = 0;

  ip_codma_crc_engine dut (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .start_i (start_i),
    .chain_i (chain_i),
    .len_i   (len_i),
    .data_i  (data_i),
    .busy_o  (busy_o),
    .done_o  (done_o),
    .crc_o   (crc_o)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) cyc_cnt <= cyc_cnt + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Bitwise reflected CRC-32 of one word, bytes LSB-first.
  function automatic logic [31:0] fold_word(input logic [31:0] c, input logic [31:0] w);
    logic [31:0] r;
    r = c;
    for (int b = 0; b < 32; b++) begin
      if (r[0] ^ w[b]) r = (r >> 1) ^ 32'hEDB88320;
      else             r = r >> 1;
    end
    return r;
  endfunction

  always @(negedge clk_i) begin
    if (done_o) begin
      if (sb_q.size() == 0) begin
        check_eq("spurious_done", 32'(done_o), 32'd0);
      end else begin
        got_e = sb_q.pop_front();
        check_eq("crc", crc_o, got_e.crc);
        check_eq("done_cycle", 32'(cyc_cnt), 32'(got_e.due));
      end
      prev_done_cyc = last_done_cyc;
      last_done_cyc = cyc_cnt;
      last_crc      = crc_o;
      $display("txn done cyc=%0d crc=%h", cyc_cnt, crc_o);
    end else if (!reset_i) begin
      check_eq("crc_hold", crc_o, prev_crc);
    end
    prev_crc = crc_o;
  end

  task automatic start_run(input logic [7:0][31:0] d, input int len, input bit chain,
                           input bit expect_done);
    int          l;
    logic [31:0] s;
    l = (len > 8) ? 8 : len;
    @(negedge clk_i);
    s = chain ? model_state : 32'hFFFFFFFF;
    for (int i = 0; i < l; i++) s = fold_word(s, d[i]);
    model_state = s;
    data_i  = d;
    len_i   = len[3:0];
    chain_i = chain;
    start_i = 1'b1;
    if (expect_done) begin
      exp_e.crc = s ^ 32'hFFFFFFFF;
      exp_e.due = cyc_cnt + 1 + l;
      sb_q.push_back(exp_e);
    end
    @(posedge clk_i);
    #1;
    start_i = 1'b0;
    for (int i = 0; i < 8; i++) data_i[i] = $urandom;
    len_i = 4'($urandom);
    check_eq("busy_after_start", 32'(busy_o), 32'd1);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!done_o && n < 40) begin
      @(posedge clk_i);
      #1;
      n++;
    end
    check_eq("done_seen", 32'(done_o), 32'd1);
    if (!done_o) sb_q.delete();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0][31:0] d;
    logic [31:0]      chain_res;
    logic [31:0]      full_res;

    reset_i = 1'b1;
    start_i = 1'b1;
    chain_i = 1'b0;
    len_i   = 4'd1;
    data_i  = '0;
    repeat (3) @(negedge clk_i);
    check_eq("reset_busy", 32'(busy_o), 32'd0);
    check_eq("reset_done", 32'(done_o), 32'd0);
    check_eq("reset_crc", crc_o, 32'h0);
    reset_i = 1'b0;
    start_i = 1'b0;
    @(negedge clk_i);
    check_eq("idle_busy", 32'(busy_o), 32'd0);

    d = '0;
    d[0] = 32'h64636261;
    start_run(d, 1, 1'b0, 1'b1);
    wait_done();
    check_eq("abcd_vec", last_crc, 32'hED82CD11);

    d = '0;
    start_run(d, 1, 1'b0, 1'b1);
    wait_done();
    check_eq("zero_vec", last_crc, 32'h2144DF1C);

    start_run(d, 0, 1'b0, 1'b1);
    wait_done();
    check_eq("empty_vec", last_crc, 32'h0);

    d[0] = 32'h64636261;
    start_run(d, 1, 1'b0, 1'b1);
    wait_done();
    start_run(d, 1, 1'b1, 1'b1);
    wait_done();
    chain_res = last_crc;
    check_eq("chain_spacing", 32'(last_done_cyc - prev_done_cyc), 32'd3);
    d[1] = 32'h64636261;
    start_run(d, 2, 1'b0, 1'b1);
    wait_done();
    check_eq("chain_match", last_crc, chain_res);

    for (int i = 0; i < 8; i++) d[i] = $urandom;
    start_run(d, 8, 1'b0, 1'b1);
    repeat (3) begin
      @(negedge clk_i);
      start_i = 1'b1;
      chain_i = 1'($urandom);
      len_i   = 4'($urandom);
      @(negedge clk_i);
      start_i = 1'b0;
    end
    wait_done();
    full_res = last_crc;
    start_run(d, 15, 1'b0, 1'b1);
    wait_done();
    check_eq("clamp_match", last_crc, full_res);

    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < 8; i++) d[i] = $urandom;
      start_run(d, $urandom_range(0, 9), 1'($urandom), 1'b1);
      wait_done();
    end

    for (int i = 0; i < 8; i++) d[i] = $urandom;
    start_run(d, 8, 1'b0, 1'b0);
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    reset_i = 1'b1;
    repeat (2) @(negedge clk_i);
    check_eq("midreset_busy", 32'(busy_o), 32'd0);
    check_eq("midreset_done", 32'(done_o), 32'd0);
    check_eq("midreset_crc", crc_o, 32'h0);
    reset_i = 1'b0;
    model_state = 32'hFFFFFFFF;
    repeat (12) @(negedge clk_i);
    check_eq("midreset_idle", 32'(busy_o), 32'd0);

    d = '0;
    d[0] = 32'h64636261;
    start_run(d, 1, 1'b0, 1'b1);
    wait_done();
    check_eq("post_reset_abcd", last_crc, 32'hED82CD11);
    start_run(d, 1, 1'b1, 1'b1);
    wait_done();
    check_eq("post_reset_chain", last_crc, chain_res);

    repeat (3) @(negedge clk_i);
    check_eq("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
